// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, branch/jump redirect,
// fetch-wait bubbles, plus saturating stall/flush event counters.
module hazard_ctrl #(
   parameter int MDU_CYCLES = 32,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UseRt,
   input  logic             IFID_UseHiLo,
   input  logic             MduStart,
   input  logic             BranchTaken,
   input  logic             Jump,
   input  logic             ImemReady,
   output logic             PCWr,
   output logic             IFIDWr,
   output logic             IFlush,
   output logic             IDEXBubble,
   output logic             MduBusy,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int              MW       = $clog2(MDU_CYCLES + 1);
   localparam logic [MW-1:0]   MDU_LOAD = MW'(MDU_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use, mdu_haz, stall;

   always_comb begin
      load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                 ((IDEX_Rt == IFID_Rs) || (IFID_UseRt && (IDEX_Rt == IFID_Rt)));
      mdu_haz  = (mdu_cnt_q != '0) && (IFID_UseHiLo || MduStart);
      stall    = load_use || mdu_haz;
   end

   // Priority: reset clear, stall, redirect, fetch wait, normal advance.
   always_comb begin
      PCWr       = 1'b1;
      IFIDWr     = 1'b1;
      IFlush     = 1'b0;
      IDEXBubble = 1'b0;
      if (rst) begin
         PCWr       = 1'b0;
         IFlush     = 1'b1;
         IDEXBubble = 1'b1;
      end else if (stall) begin
         PCWr       = 1'b0;
         IFIDWr     = 1'b0;
         IDEXBubble = 1'b1;
      end else if (BranchTaken || Jump) begin
         IFlush     = 1'b1;
      end else if (!ImemReady) begin
         PCWr       = 1'b0;
         IFlush     = 1'b1;
      end
   end

   always_comb begin
      mdu_cnt_d   = mdu_cnt_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (rst) begin
         mdu_cnt_d   = '0;
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (MduStart && !stall)
            mdu_cnt_d = MDU_LOAD;
         else if (mdu_cnt_q != '0)
            mdu_cnt_d = mdu_cnt_q - MW'(1);
         if (!IFIDWr && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (IFlush && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
   end

   assign MduBusy  = (mdu_cnt_q != '0);
   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a cycle-indexed behavioural model of the hazard rules.
module tb_hazard_ctrl;

   localparam int MDU = 4;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          IDEX_MemRead;
   logic [4:0]    IDEX_Rt, IFID_Rs, IFID_Rt;
   logic          IFID_UseRt, IFID_UseHiLo, MduStart, BranchTaken, Jump, ImemReady;
   logic          PCWr, IFIDWr, IFlush, IDEXBubble, MduBusy;
   logic [CW-1:0] StallCnt, FlushCnt;

   int total = 0;
   int bad   = 0;

   // model state: cycle index, last cycle the MDU is still occupied, counters
   int cyc;
   int last_busy;
   int m_stall, m_flush;
   logic e_pc, e_ifid, e_flush, e_bub, e_busy;

   hazard_ctrl #(.MDU_CYCLES(MDU), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UseRt(IFID_UseRt),
      .IFID_UseHiLo(IFID_UseHiLo), .MduStart(MduStart),
      .BranchTaken(BranchTaken), .Jump(Jump), .ImemReady(ImemReady),
      .PCWr(PCWr), .IFIDWr(IFIDWr), .IFlush(IFlush), .IDEXBubble(IDEXBubble),
      .MduBusy(MduBusy), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle();
      rst = 0; IDEX_MemRead = 0; IDEX_Rt = 0; IFID_Rs = 0; IFID_Rt = 0;
      IFID_UseRt = 0; IFID_UseHiLo = 0; MduStart = 0; BranchTaken = 0;
      Jump = 0; ImemReady = 1;
   endtask

   // Evaluate the rules for the current inputs and compare at the falling edge.
   task automatic eval_cycle();
      bit lu, st;
      @(negedge clk);
      e_busy = (cyc <= last_busy);
      lu = IDEX_MemRead && IDEX_Rt != 0 &&
           (IDEX_Rt == IFID_Rs || (IFID_UseRt && IDEX_Rt == IFID_Rt));
      st = lu || (e_busy && (IFID_UseHiLo || MduStart));
      if (rst)                     {e_pc, e_ifid, e_flush, e_bub} = 4'b0111;
      else if (st)                 {e_pc, e_ifid, e_flush, e_bub} = 4'b0001;
      else if (BranchTaken || Jump){e_pc, e_ifid, e_flush, e_bub} = 4'b1110;
      else if (!ImemReady)         {e_pc, e_ifid, e_flush, e_bub} = 4'b0110;
      else                         {e_pc, e_ifid, e_flush, e_bub} = 4'b1100;
      chk("PCWr", PCWr, e_pc);
      chk("IFIDWr", IFIDWr, e_ifid);
      chk("IFlush", IFlush, e_flush);
      chk("IDEXBubble", IDEXBubble, e_bub);
      chk("MduBusy", MduBusy, e_busy);
      chk("StallCnt", StallCnt, m_stall);
      chk("FlushCnt", FlushCnt, m_flush);
   endtask

   // Apply the cycle's effects to the model, then cross the rising edge.
   task automatic advance();
      if (rst) begin
         m_stall = 0; m_flush = 0; last_busy = cyc;
      end else begin
         if (!e_ifid) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
         if (e_flush) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
         if (MduStart && e_ifid) last_busy = cyc + MDU;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      eval_cycle();
      advance();
   endtask

   int s0, f0;

   initial begin
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      cyc = 0; last_busy = -1; m_stall = 0; m_flush = 0;

      // reset cycle: pipeline cleared
      eval_cycle();
      chk("rst_pcwr", PCWr, 0);
      chk("rst_iflush", IFlush, 1);
      chk("rst_bubble", IDEXBubble, 1);
      advance();

      // load-use on rs, then same pattern with Rt=0
      idle();
      IDEX_MemRead = 1; IDEX_Rt = 5; IFID_Rs = 5;
      eval_cycle();
      chk("lu_pcwr", PCWr, 0);
      chk("lu_ifidwr", IFIDWr, 0);
      chk("lu_bubble", IDEXBubble, 1);
      advance();
      idle();
      IDEX_MemRead = 1; IDEX_Rt = 0; IFID_Rs = 0;
      eval_cycle();
      chk("lu_r0_pcwr", PCWr, 1);
      advance();
      chk("lu_stallcnt", StallCnt, 1);

      // branch redirect while fetch not ready
      idle();
      BranchTaken = 1; ImemReady = 0;
      f0 = m_flush;
      eval_cycle();
      chk("br_pcwr", PCWr, 1);
      chk("br_iflush", IFlush, 1);
      advance();
      chk("br_flushcnt", FlushCnt, f0 + 1);

      // load-use and branch together: stall wins, branch follows
      idle();
      IDEX_MemRead = 1; IDEX_Rt = 7; IFID_Rt = 7; IFID_UseRt = 1; BranchTaken = 1;
      eval_cycle();
      chk("lub_iflush", IFlush, 0);
      chk("lub_bubble", IDEXBubble, 1);
      advance();
      IDEX_MemRead = 0;
      eval_cycle();
      chk("lub_next_iflush", IFlush, 1);
      advance();

      // mult/div issue followed by a HI/LO consumer
      idle();
      MduStart = 1;
      step();
      idle();
      IFID_UseHiLo = 1;
      s0 = m_stall;
      for (int i = 1; i <= MDU; i++) begin
         eval_cycle();
         chk("mdu_hold", IFIDWr, 0);
         advance();
      end
      eval_cycle();
      chk("mdu_release", IFIDWr, 1);
      advance();
      chk("mdu_stalls", StallCnt, s0 + MDU);

      // back-to-back mult/div
      idle();
      MduStart = 1;
      step();
      for (int i = 1; i <= MDU; i++) step();
      eval_cycle();
      chk("b2b_issue", IFIDWr, 1);
      advance();
      idle();
      eval_cycle();
      chk("b2b_busy", MduBusy, 1);
      advance();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst          = ($urandom_range(0, 59) == 0);
         IDEX_MemRead = ($urandom_range(0, 2) == 0);
         IDEX_Rt      = 5'($urandom_range(0, 3));
         IFID_Rs      = 5'($urandom_range(0, 3));
         IFID_Rt      = 5'($urandom_range(0, 3));
         IFID_UseRt   = 1'($urandom_range(0, 1));
         IFID_UseHiLo = ($urandom_range(0, 3) == 0);
         MduStart     = ($urandom_range(0, 5) == 0);
         BranchTaken  = ($urandom_range(0, 5) == 0);
         Jump         = ($urandom_range(0, 9) == 0);
         ImemReady    = ($urandom_range(0, 4) != 0);
         step();
      end

      // reset in the middle of a mult/div
      idle();
      MduStart = 1;
      step();
      idle();
      step();
      rst = 1;
      eval_cycle();
      chk("midrst_busy", MduBusy, 1);
      advance();
      idle();
      eval_cycle();
      chk("post_rst_busy", MduBusy, 0);
      chk("post_rst_stall", StallCnt, 0);
      chk("post_rst_flush", FlushCnt, 0);
      advance();

      // long fetch wait saturates the flush counter
      rst = 1;
      step();
      idle();
      ImemReady = 0;
      for (int i = 0; i < 20; i++) step();
      idle();
      eval_cycle();
      chk("sat_flush", FlushCnt, 15);
      chk("sat_stall", StallCnt, 0);
      advance();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
